// File: rtl/mac8_seq_ctrl.sv
// mac8_seq_ctrl: 8x8 unsigned MAC built from one 2-bit vedic multiplier sequenced over 16 digit pairs

// 2x2 vedic multiplier: pure combinational, the only arithmetic array in the design
module vedic_2bit_multiplier (
    input  logic [1:0] i_a,
    input  logic [1:0] i_b,
    output logic [3:0] o_p
);
    logic w_hi;
    logic w_mid;
    logic w_c;
    assign w_hi  = i_a[1] & i_b[1];
    assign w_mid = (i_a[1] & i_b[0]) ^ (i_a[0] & i_b[1]);
    assign w_c   = i_a[1] & i_b[0] & i_a[0] & i_b[1];
    assign o_p   = {w_hi & w_c, w_hi ^ w_c, w_mid, i_a[0] & i_b[0]};
endmodule

module mac8_seq_ctrl #(
    parameter int ACC_W = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       a,
    input  logic [7:0]       b,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      product,
    output logic [ACC_W-1:0] acc,
    output logic             ovf,
    output logic             busy
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_ACC  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       r_state;
    logic [3:0]       r_cnt;
    logic [7:0]       r_a;
    logic [7:0]       r_b;
    logic             r_clr;
    logic [15:0]      r_product;
    logic [ACC_W-1:0] r_acc;
    logic             r_ovf;

    logic [1:0]       w_da;
    logic [1:0]       w_db;
    logic [3:0]       w_p;
    logic [3:0]       w_shift;
    logic [15:0]      w_pp;
    logic [ACC_W:0]   w_sum;

    // cnt[3:2] picks the multiplicand digit, cnt[1:0] the multiplier digit
    assign w_da    = 2'(r_a >> {r_cnt[3:2], 1'b0});
    assign w_db    = 2'(r_b >> {r_cnt[1:0], 1'b0});
    assign w_shift = {1'b0, r_cnt[3:2], 1'b0} + {1'b0, r_cnt[1:0], 1'b0};
    assign w_pp    = 16'(w_p) << w_shift;
    assign w_sum   = {1'b0, r_acc} + (ACC_W + 1)'(r_product);

    vedic_2bit_multiplier u_mul (
        .i_a (w_da),
        .i_b (w_db),
        .o_p (w_p)
    );

    assign in_ready  = r_state == S_IDLE;
    assign out_valid = r_state == S_DONE;
    assign busy      = r_state != S_IDLE;
    assign product   = r_product;
    assign acc       = r_acc;
    assign ovf       = r_ovf;

    // Sequencer: accept operands, sweep 16 digit pairs, fold into accumulator, hold result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_clr     <= 1'b0;
            r_product <= '0;
            r_acc     <= '0;
            r_ovf     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (in_valid) begin
                    r_a       <= a;
                    r_b       <= b;
                    r_clr     <= acc_clr;
                    r_product <= '0;
                    r_cnt     <= '0;
                    r_state   <= S_MUL;
                end
                S_MUL: begin
                    r_product <= r_product + w_pp;
                    r_cnt     <= r_cnt + 4'd1;
                    r_state   <= r_cnt == 4'd15 ? S_ACC : S_MUL;
                end
                S_ACC: begin
                    r_acc   <= r_clr ? ACC_W'(r_product) : w_sum[ACC_W-1:0];
                    r_ovf   <= r_clr ? 1'b0 : r_ovf | w_sum[ACC_W];
                    r_state <= S_DONE;
                end
                default: if (out_ready) r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mac8_seq_ctrl.sv
// tb_mac8_seq_ctrl: directed and random checks of mac8_seq_ctrl at ACC_W=20 and ACC_W=16 side by side
module tb_mac8_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        acc_clr;
    logic        out_ready;

    logic        in_ready20, out_valid20, ovf20, busy20;
    logic [15:0] product20;
    logic [19:0] acc20;
    logic        in_ready16, out_valid16, ovf16, busy16;
    logic [15:0] product16;
    logic [15:0] acc16;

    logic [19:0] m_acc20;
    logic        m_ovf20;
    logic [15:0] m_acc16;
    logic        m_ovf16;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mac8_seq_ctrl #(.ACC_W(20)) dut20 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready20),
        .a(a), .b(b), .acc_clr(acc_clr), .out_valid(out_valid20), .out_ready(out_ready),
        .product(product20), .acc(acc20), .ovf(ovf20), .busy(busy20)
    );

    mac8_seq_ctrl #(.ACC_W(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready16),
        .a(a), .b(b), .acc_clr(acc_clr), .out_valid(out_valid16), .out_ready(out_ready),
        .product(product16), .acc(acc16), .ovf(ovf16), .busy(busy16)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_product20"}, 32'(product20), 32'h0);
        check({tag, "_acc20"}, 32'(acc20), 32'h0);
        check({tag, "_ovf20"}, 32'(ovf20), 32'h0);
        check({tag, "_out_valid20"}, 32'(out_valid20), 32'h0);
        check({tag, "_busy20"}, 32'(busy20), 32'h0);
        check({tag, "_product16"}, 32'(product16), 32'h0);
        check({tag, "_acc16"}, 32'(acc16), 32'h0);
        check({tag, "_busy16"}, 32'(busy16), 32'h0);
    endtask

    task automatic check_result(input string tag, input logic [15:0] p);
        check({tag, "_out_valid16"}, 32'(out_valid16), 32'h1);
        check({tag, "_product20"}, 32'(product20), 32'(p));
        check({tag, "_acc20"}, 32'(acc20), 32'(m_acc20));
        check({tag, "_ovf20"}, 32'(ovf20), 32'(m_ovf20));
        check({tag, "_product16"}, 32'(product16), 32'(p));
        check({tag, "_acc16"}, 32'(acc16), 32'(m_acc16));
        check({tag, "_ovf16"}, 32'(ovf16), 32'(m_ovf16));
    endtask

    task automatic run_op(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                          input logic iclr, input int stall);
        logic [15:0] p;
        logic [20:0] s20;
        logic [16:0] s16;
        int n;
        check({tag, "_in_ready_idle"}, 32'(in_ready20 & in_ready16), 32'h1);
        a = ia;
        b = ib;
        acc_clr = iclr;
        in_valid = 1'b1;
        out_ready = stall == 0;
        step;
        in_valid = 1'b0;
        p = 16'(ia) * 16'(ib);
        s20 = 21'(m_acc20) + 21'(p);
        s16 = 17'(m_acc16) + 17'(p);
        m_acc20 = iclr ? 20'(p) : s20[19:0];
        m_ovf20 = iclr ? 1'b0 : m_ovf20 | s20[20];
        m_acc16 = iclr ? p : s16[15:0];
        m_ovf16 = iclr ? 1'b0 : m_ovf16 | s16[16];
        check({tag, "_busy"}, 32'(busy20 & busy16), 32'h1);
        n = 0;
        while (!out_valid20 && n < 40) begin
            check({tag, "_in_ready_busy"}, 32'(in_ready20 | in_ready16), 32'h0);
            in_valid = 1'($urandom_range(0, 1));
            a = 8'($urandom);
            b = 8'($urandom);
            acc_clr = 1'($urandom);
            step;
            n++;
        end
        in_valid = 1'b0;
        check({tag, "_latency"}, 32'(n), 32'd17);
        check_result(tag, p);
        for (int k = 0; k < stall; k++) begin
            step;
            check({tag, "_hold_valid"}, 32'(out_valid20 & out_valid16), 32'h1);
            check({tag, "_hold_in_ready"}, 32'(in_ready20 | in_ready16), 32'h0);
            check({tag, "_hold_product"}, 32'(product20), 32'(p));
            check({tag, "_hold_acc"}, 32'(acc20), 32'(m_acc20));
        end
        out_ready = 1'b1;
        step;
        out_ready = 1'b0;
        check({tag, "_done_valid_low"}, 32'(out_valid20 | out_valid16), 32'h0);
        check({tag, "_back_in_ready"}, 32'(in_ready20 & in_ready16), 32'h1);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        acc_clr = 1'b0;
        out_ready = 1'b0;
        m_acc20 = '0;
        m_ovf20 = 1'b0;
        m_acc16 = '0;
        m_ovf16 = 1'b0;
        #12;
        check_idle_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        step;
        check("reset_in_ready", 32'(in_ready20 & in_ready16), 32'h1);

        run_op("ff_x_ff", 8'hFF, 8'hFF, 1'b1, 0);
        check("ff_x_ff_acc20_const", 32'(acc20), 32'h0FE01);

        run_op("3x5", 8'd3, 8'd5, 1'b1, 1);
        check("3x5_acc_const", 32'(acc20), 32'd15);
        run_op("7x9", 8'd7, 8'd9, 1'b0, 2);
        check("7x9_acc_const", 32'(acc20), 32'd78);

        run_op("wrap1", 8'hFF, 8'hFF, 1'b1, 0);
        run_op("wrap2", 8'hFF, 8'hFF, 1'b0, 0);
        check("wrap2_acc16_const", 32'(acc16), 32'hFC02);
        check("wrap2_ovf16_const", 32'(ovf16), 32'h1);
        check("wrap2_acc20_const", 32'(acc20), 32'h1FC02);
        run_op("wrap3", 8'd2, 8'd2, 1'b0, 0);
        check("wrap3_acc16_const", 32'(acc16), 32'hFC06);
        check("wrap3_ovf16_const", 32'(ovf16), 32'h1);
        run_op("wrap4", 8'd1, 8'd1, 1'b1, 0);
        check("wrap4_acc16_const", 32'(acc16), 32'h1);
        check("wrap4_ovf16_const", 32'(ovf16), 32'h0);

        run_op("backpressure", 8'hAB, 8'hCD, 1'b0, 10);

        check("midrst_in_ready", 32'(in_ready20), 32'h1);
        a = 8'h55;
        b = 8'hAA;
        acc_clr = 1'b0;
        in_valid = 1'b1;
        step;
        in_valid = 1'b0;
        repeat (7) step;
        #2;
        rst = 1'b1;
        #1;
        check_idle_outputs("midrst");
        check("midrst_in_ready_low_rst", 32'(in_ready20 & in_ready16), 32'h1);
        @(negedge clk);
        rst = 1'b0;
        step;
        m_acc20 = '0;
        m_ovf20 = 1'b0;
        m_acc16 = '0;
        m_ovf16 = 1'b0;
        run_op("after_rst", 8'h12, 8'h34, 1'b0, 0);
        check("after_rst_product_const", 32'(product20), 32'h03A8);
        check("after_rst_acc_const", 32'(acc20), 32'h003A8);

        for (int i = 0; i < 1000; i++)
            run_op("random", 8'($urandom), 8'($urandom), $urandom_range(0, 7) == 0,
                   int'($urandom_range(0, 3)));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
